// File: rtl/mshr_pkg.sv
// Shared types and field layout for the miss-status release controller.
package mshr_pkg;

  localparam int MSHR_DEPTH        = 8;
  localparam int MSHR_DATA_WIDTH   = 74;
  localparam int MSHR_STARVE_LIMIT = 4;

  // Entry layout, LSB upward: SB entry, SB release valid, active mask, latency, warp ID, ...
  localparam int MSHR_MASK_LSB = 7;
  localparam int MSHR_MASK_W   = 8;
  localparam int MSHR_LAT_LSB  = 15;
  localparam int MSHR_LAT_W    = 3;
  localparam int MSHR_WARP_LSB = 18;
  localparam int MSHR_WARP_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2
  } mshr_state_e;

endpackage

// File: rtl/mshr_entry_fifo.sv
// Synchronous pointer FIFO holding pending miss entries; pointers carry an extra wrap bit.
module mshr_entry_fifo
  import mshr_pkg::*;
#(
  parameter int DEPTH      = MSHR_DEPTH,
  parameter int DATA_WIDTH = MSHR_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   head_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]           wptr_q, wptr_d;
  logic [AW:0]           rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  do_push, do_pop;

  assign full      = (wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}};
  assign empty     = (wptr_q == rptr_q);
  assign count     = wptr_q - rptr_q;
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: contents are only visible behind a valid pointer.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mshr_release_ctrl.sv
// Miss-path sequencer: buffers misses, models fill latency, arbitrates the WB port with hits.
// Define MSHR_STARVE_GUARD_EN to force a starved hit through after STARVE_LIMIT cycles.
module mshr_release_ctrl
  import mshr_pkg::*;
#(
  parameter int DEPTH        = MSHR_DEPTH,
  parameter int DATA_WIDTH   = MSHR_DATA_WIDTH,
  parameter int LAT_LSB      = MSHR_LAT_LSB,
  parameter int STARVE_LIMIT = MSHR_STARVE_LIMIT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss_valid,
  output logic                    miss_ready,
  input  logic [DATA_WIDTH-1:0]   miss_data,
  input  logic                    hit_valid,
  output logic                    hit_ready,
  input  logic [DATA_WIDTH-1:0]   hit_data,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [DATA_WIDTH-1:0]   wb_data,
  output logic                    wb_is_miss,
  output logic                    mshr_empty,
  output logic [$clog2(DEPTH):0]  mshr_count
);

  mshr_state_e           state_q, state_d;
  logic [MSHR_LAT_W-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  fifo_full, fifo_empty;
  logic                  push, pop;
  logic                  in_issue, miss_sel, miss_fire, force_hit;

  // No bypass: a full FIFO refuses even when a pop lands in the same cycle.
  assign miss_ready = ~fifo_full;
  assign push       = miss_valid & ~fifo_full;

  mshr_entry_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (miss_data),
    .pop       (pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (mshr_count)
  );

`ifdef MSHR_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q, starve_d;

  assign force_hit = hit_valid & (starve_q == SW'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (hit_ready)
      starve_d = '0;
    else if (hit_valid && (starve_q != SW'(STARVE_LIMIT)))
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  assign force_hit = 1'b0;
`endif

  assign in_issue   = (state_q == ST_ISSUE);
  assign miss_sel   = in_issue & ~force_hit;
  assign miss_fire  = miss_sel & wb_ready;
  assign wb_valid   = in_issue | hit_valid;
  assign wb_is_miss = miss_sel;
  assign wb_data    = miss_sel ? hold_q : hit_data;
  assign hit_ready  = hit_valid & wb_ready & ~miss_sel;
  assign mshr_empty = fifo_empty & (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE:  pop = ~fifo_empty;
      ST_WAIT: begin
        if (cnt_q != '0) cnt_d   = cnt_q - 1'b1;
        else             state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (miss_fire) begin
          pop     = ~fifo_empty;
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
    // Any pop (from IDLE or straight out of ISSUE) loads the next entry's countdown.
    if (pop) begin
      hold_d  = head_data;
      cnt_d   = head_data[LAT_LSB +: MSHR_LAT_W];
      state_d = ST_WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_mshr_release_ctrl.sv
// Scoreboard bench for mshr_release_ctrl (default build, strict miss priority).
module tb_mshr_release_ctrl;
  import mshr_pkg::*;

  localparam int DW    = MSHR_DATA_WIDTH;
  localparam int DEPTH = MSHR_DEPTH;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   miss_valid, miss_ready;
  logic [DW-1:0]          miss_data;
  logic                   hit_valid, hit_ready;
  logic [DW-1:0]          hit_data;
  logic                   wb_valid, wb_ready, wb_is_miss;
  logic [DW-1:0]          wb_data;
  logic                   mshr_empty;
  logic [$clog2(DEPTH):0] mshr_count;

  int            n_chk  = 0;
  int            n_fail = 0;
  logic [DW-1:0] exp_miss_q[$];
  logic [DW-1:0] exp_hit_q[$];
  logic [DW-1:0] e, h;

  mshr_release_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .miss_valid (miss_valid),
    .miss_ready (miss_ready),
    .miss_data  (miss_data),
    .hit_valid  (hit_valid),
    .hit_ready  (hit_ready),
    .hit_data   (hit_data),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_data    (wb_data),
    .wb_is_miss (wb_is_miss),
    .mshr_empty (mshr_empty),
    .mshr_count (mshr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [MSHR_WARP_W-1:0] warp,
                                       input logic [MSHR_LAT_W-1:0] lat);
    logic [DW-1:0] r;
    r = DW'({$urandom(), $urandom(), $urandom()});
    r[MSHR_LAT_LSB +: MSHR_LAT_W]   = lat;
    r[MSHR_WARP_LSB +: MSHR_WARP_W] = warp;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_miss(input logic [DW-1:0] d);
    miss_valid = 1'b1;
    miss_data  = d;
    exp_miss_q.push_back(d);
    step();
    miss_valid = 1'b0;
  endtask

  task automatic wait_wbv(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = wb_valid;
    end
    chk(tag, wb_valid, 1);
  endtask

  task automatic wait_empty(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = mshr_empty;
    end
    chk(tag, mshr_empty, 1);
  endtask

  // Every WB transfer is matched, in order, against the queue of its source path.
  always @(negedge clk) begin
    if (!rst && wb_valid && wb_ready) begin
      if (wb_is_miss) begin
        if (exp_miss_q.size() == 0) chk("sb_miss_extra", exp_miss_q.size(), 1);
        else                        chk("sb_miss_data", wb_data, exp_miss_q.pop_front());
      end else begin
        if (exp_hit_q.size() == 0)  chk("sb_hit_extra", exp_hit_q.size(), 1);
        else                        chk("sb_hit_data", wb_data, exp_hit_q.pop_front());
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; miss_valid = 1'b0; miss_data = '0;
    hit_valid = 1'b0; hit_data = '0; wb_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_miss_ready", miss_ready, 1);
    chk("rst_hit_ready", hit_ready, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_is_miss", wb_is_miss, 0);
    chk("rst_empty", mshr_empty, 1);
    chk("rst_count", mshr_count, 0);
    step();

    // Single miss, latency 3: released on cycle 6 for one cycle
    wb_ready = 1'b1;
    e = mk(5'd1, 3'd3);
    miss_valid = 1'b1; miss_data = e; exp_miss_q.push_back(e);
    step();
    miss_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk("t_single_wbv", wb_valid, (c == 6));
      chk("t_single_ism", wb_is_miss, (c == 6));
      if (c == 3) chk("t_single_busy", mshr_empty, 0);
      if (c == 7) chk("t_single_empty", mshr_empty, 1);
    end
    step();

    // Fill: one entry in flight plus 8 buffered; 10th attempt refused
    wb_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      e = mk(5'(i), 3'd7);
      miss_valid = 1'b1; miss_data = e; exp_miss_q.push_back(e);
      @(negedge clk);
      chk("t_fill_ready", miss_ready, 1);
      step();
    end
    miss_data = mk(5'd31, 3'd7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t_full_ready", miss_ready, 0);
      chk("t_full_count", mshr_count, 8);
      step();
    end
    miss_valid = 1'b0;
    wait_wbv("t_full_issue");
    chk("t_full_hold", mshr_count, 8);
    step();
    wb_ready = 1'b1;
    @(negedge clk);
    chk("t_full_prepop", mshr_count, 8);
    step();
    @(negedge clk);
    chk("t_full_pop", mshr_count, 7);
    wait_empty("t_full_drain", 150);
    step();

    // Latency 0 back-to-back across the pointer wrap: one release every 2 cycles
    wb_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_miss(mk(5'(i), 3'd0));
    step(); step();
    @(negedge clk);
    chk("t_b2b_count", mshr_count, 7);
    step();
    wb_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk("t_b2b_wbv", wb_valid, (c % 2 == 0));
      chk("t_b2b_ism", wb_is_miss, (c % 2 == 0));
      if (c == 15) chk("t_b2b_empty", mshr_empty, 1);
    end
    step();

    // Hit collides with a miss in ISSUE: miss first, hit the next cycle
    wb_ready = 1'b0;
    push_miss(mk(5'd2, 3'd1));
    wait_wbv("t_col_issue");
    step();
    h = mk(5'd20, 3'd5);
    hit_valid = 1'b1; hit_data = h; wb_ready = 1'b1; exp_hit_q.push_back(h);
    @(negedge clk);
    chk("t_col_hrdy0", hit_ready, 0);
    chk("t_col_ism1", wb_is_miss, 1);
    step();
    @(negedge clk);
    chk("t_col_hrdy1", hit_ready, 1);
    chk("t_col_ism0", wb_is_miss, 0);
    chk("t_col_data", wb_data, h);
    step();
    hit_valid = 1'b0;

    // WB stall during ISSUE: payload frozen, release on first ready cycle
    wb_ready = 1'b0;
    e = mk(5'd3, 3'd2);
    push_miss(e);
    wait_wbv("t_stall_issue");
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      chk("t_stall_wbv", wb_valid, 1);
      chk("t_stall_data", wb_data, e);
    end
    step();
    wb_ready = 1'b1;
    @(negedge clk);
    chk("t_stall_fire", wb_valid & wb_is_miss, 1);
    step();
    @(negedge clk);
    chk("t_stall_done", wb_valid, 0);
    chk("t_stall_empty", mshr_empty, 1);
    step();

    // Reset during WAIT with 3 entries queued
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_miss(mk(5'(10 + i), 3'd7));
    @(negedge clk);
    chk("t_rst_pre_count", mshr_count, 3);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_miss_q.delete();
    @(negedge clk);
    chk("t_rst_count", mshr_count, 0);
    chk("t_rst_empty", mshr_empty, 1);
    chk("t_rst_wbv", wb_valid, 0);
    chk("t_rst_mrdy", miss_ready, 1);
    step();
    wb_ready = 1'b1;
    push_miss(mk(5'd9, 3'd0));
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("t_rst_after_wbv", wb_valid, (c == 3));
    end
    step();

    chk("sb_miss_left", exp_miss_q.size(), 0);
    chk("sb_hit_left", exp_hit_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
